dm_abstract_access: RTL and testbench
=====================================

// Module: dm_abstract_access
// PURPOSE
//  Debug-module abstract-command engine: the initiator for the core's CSR-access and register-file ports.
//  Executes "Access Register" commands (32-bit only) against CSRs (regno 0x0000-0x0FFF) or GPRs (0x1000-0x101F),
//  moving data between the DM data0 register and the hart; reports sticky cmderr; sits between dmi regs and the core.
// PARAMETERS
//  GprBase      16'h1000  first regno mapped to x0
//  GprCount     32        number of GPRs mapped
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   reset, synchronous, active-low
//  cmd_valid     in   1   command strobe from dmi write of "command" (one cycle)
//  cmd_aarsize   in   3   access size; only 3'd2 supported
//  cmd_postinc   in   1   increment regno after transfer
//  cmd_transfer  in   1   1 = perform transfer, 0 = no-op
//  cmd_write     in   1   1 = data0 -> reg, 0 = reg -> data0
//  cmd_regno     in   16  register number
//  halted        in   1   hart in debug mode
//  cmderr_clr    in   3   W1C mask for cmderr
//  data0_in      in   32  current data0
//  data0_out     out  32  value to load into data0
//  data0_we      out  1   data0 load strobe
//  regno_out     out  16  incremented regno
//  regno_we      out  1   command.regno update strobe
//  busy          out  1   abstractcs.busy
//  cmderr        out  3   abstractcs.cmderr (sticky)
//  csr_addr      out  12  CSR address to core
//  csr_f3        out  3   CSR funct3: 3'b010 read (CSRRS, rs=0), 3'b001 write (CSRRW)
//  csr_wdata     out  32  CSR write value (reg_in)
//  csr_rs        out  5   always 0
//  csr_write     out  1   CSR commit strobe
//  csr_rdata     in   32  CSR read value (combinational from csr_addr/csr_f3)
//  csr_invalid   in   1   CSR access illegal (combinational)
//  rf_addr       out  5   GPR index
//  rf_rdata      in   32  GPR read data (combinational)
//  rf_wdata      out  32  GPR write data
//  rf_we         out  1   GPR write strobe (x0 writes dropped by rf)
// BEHAVIOUR
//  Reset: state IDLE, busy=0, cmderr=0, all strobes 0, csr_addr/rf_addr/data outs 0, csr_f3=3'b010.
//  FSM: IDLE -> CHECK -> (READ | WRITE) -> [INC] -> IDLE; any error -> IDLE.
//  IDLE: on cmd_valid with cmderr==0 latch command, busy=1, go CHECK. cmd_valid with cmderr!=0 ignored.
//  CHECK (1 cycle): priority: !halted -> cmderr=4; aarsize!=2 -> cmderr=2; transfer=0 -> skip to INC/IDLE;
//   regno in CSR range: drive csr_addr, csr_f3 per cmd_write; csr_invalid -> cmderr=3;
//   regno in [GprBase, GprBase+GprCount) -> GPR path; any other regno -> cmderr=3.
//  READ (1 cycle): data0_out = csr_rdata or rf_rdata, data0_we=1.
//  WRITE (1 cycle): csr_wdata/rf_wdata = data0_in; csr_write or rf_we =1; csr_f3 held at 3'b001.
//  INC: regno_out = regno+1 (16-bit, 0xFFFF wraps to 0x0000), regno_we=1; only on success, incl. transfer=0.
//  Latency: success 3 cycles (4 with INC) from cmd_valid to busy=0; error 2 cycles.
//  cmd_valid while busy: cmderr=1 (if cmderr==0), running command completes unchanged.
//  cmderr write only when currently 0 (first error sticks); cmderr &= ~cmderr_clr each cycle; a set in the
//   same cycle as a clear wins.
//  halted dropping mid-command: command completes; no re-check.
//  Reset mid-command: abort, no strobes issued in the reset cycle or after.
//  All strobes single-cycle; at most one of data0_we/csr_write/rf_we per cycle.
// CONFIGURATION
//  DM_ABSTRACT_POSTINCREMENT_EN defined: postinc honoured as INC above.
//  Not defined: cmd_postinc=1 -> cmderr=2 in CHECK; regno_we tied 0; INC state not built.
// STRUCTURE
//  Shared debug package: cmderr enum (NONE=0,BUSY=1,NOTSUP=2,EXCEPT=3,HALTRESUME=4), FSM state enum,
//   CSR/GPR regno range constants, CSR funct3 constants (shared with the core CSR file).
//  Single module; no sub-module (regno decode is small combinational logic inline).
// TESTING
//  halted=1, read regno 0x0341 (mepc=0x8000_0010) -> data0_out=0x8000_0010, data0_we pulse, busy 3 cycles, cmderr=0.
//  write regno 0x1005 data0=0xDEAD_BEEF -> rf_addr=5, rf_wdata=0xDEAD_BEEF, rf_we one cycle; x0 write dropped.
//  write to read-only CSR 0xF11 (csr_invalid=1) -> cmderr=3, no csr_write; next cmd ignored until cmderr_clr=3'b111.
//  halted=0 any cmd -> cmderr=4; aarsize=3 -> cmderr=2; regno 0x2000 -> cmderr=3; second cmd_valid while busy -> cmderr=1.
//  postinc=1, regno 0xFFFF transfer=0 -> regno_out=0x0000 with EN; cmderr=2, regno_we=0 without EN.
//  rst_n low during WRITE -> no csr_write/rf_we, busy=0, cmderr=0 next cycle.

Source files
------------

// File: rtl/dm_abstract_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_abstract_access_pkg
// Brief    : Shared debug-module types: cmderr codes, abstract-command FSM
//            states, regno map and CSR funct3 encodings.
// Revision : 1.0 - initial release
// ============================================================================
package dm_abstract_access_pkg;

   typedef enum logic [2:0] {
      CMDERR_NONE       = 3'd0,
      CMDERR_BUSY       = 3'd1,
      CMDERR_NOTSUP     = 3'd2,
      CMDERR_EXCEPT     = 3'd3,
      CMDERR_HALTRESUME = 3'd4
   } cmderr_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_INC   = 3'd4
   } state_e;

   localparam logic [15:0] c_csr_regno_last = 16'h0FFF;
   localparam logic [15:0] c_gpr_base       = 16'h1000;
   localparam int          c_gpr_count      = 32;

   localparam logic [2:0]  c_csr_f3_read    = 3'b010;
   localparam logic [2:0]  c_csr_f3_write   = 3'b001;
   localparam logic [2:0]  c_aarsize_32     = 3'd2;

endpackage
`default_nettype wire

// File: rtl/dm_abstract_access.sv
`default_nettype none
// ============================================================================
// Module   : dm_abstract_access
// Brief    : Debug-module abstract "Access Register" engine driving the core
//            CSR and GPR ports. Define DM_ABSTRACT_POSTINCREMENT_EN to build
//            regno post-increment support.
// Revision : 1.0 - initial release
// ============================================================================
module dm_abstract_access
   import dm_abstract_access_pkg::*;
#(
   parameter logic [15:0] GprBase  = c_gpr_base,
   parameter int          GprCount = c_gpr_count
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_aarsize,
   input  logic        cmd_postinc,
   input  logic        cmd_transfer,
   input  logic        cmd_write,
   input  logic [15:0] cmd_regno,
   input  logic        halted,
   input  logic [2:0]  cmderr_clr,
   input  logic [31:0] data0_in,
   output logic [31:0] data0_out,
   output logic        data0_we,
   output logic [15:0] regno_out,
   output logic        regno_we,
   output logic        busy,
   output logic [2:0]  cmderr,
   output logic [11:0] csr_addr,
   output logic [2:0]  csr_f3,
   output logic [31:0] csr_wdata,
   output logic [4:0]  csr_rs,
   output logic        csr_write,
   input  logic [31:0] csr_rdata,
   input  logic        csr_invalid,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_rdata,
   output logic [31:0] rf_wdata,
   output logic        rf_we
);

   state_e      r_state;
   cmderr_e     r_cmderr;
   logic [15:0] r_regno;
   logic        r_write;
   logic        r_transfer;
   logic        r_postinc;
   logic [2:0]  r_aarsize;
   logic        r_busy;
   logic [31:0] r_data0_out;
   logic        r_data0_we;
   logic [11:0] r_csr_addr;
   logic [2:0]  r_csr_f3;
   logic [31:0] r_csr_wdata;
   logic        r_csr_write;
   logic [4:0]  r_rf_addr;
   logic [31:0] r_rf_wdata;
   logic        r_rf_we;

   logic [16:0] w_gpr_end;
   logic        w_in_csr;
   logic        w_in_gpr;
   logic [4:0]  w_cmd_gpr_idx;
   logic        w_chk_err;
   cmderr_e     w_chk_code;
   logic        w_err_set;
   cmderr_e     w_err_code;
   state_e      w_done_state;

   assign w_gpr_end     = 17'(GprBase) + 17'(GprCount);
   assign w_in_csr      = (r_regno <= c_csr_regno_last);
   assign w_in_gpr      = (r_regno >= GprBase) && ({1'b0, r_regno} < w_gpr_end);
   assign w_cmd_gpr_idx = 5'(cmd_regno - GprBase);

`ifdef DM_ABSTRACT_POSTINCREMENT_EN
   logic [15:0] r_regno_out;
   logic        r_regno_we;
   assign w_done_state = r_postinc ? ST_INC : ST_IDLE;
`else
   assign w_done_state = ST_IDLE;
`endif

   // Legality checks in priority order; csr_addr/csr_f3 are already stable here.
   always_comb begin
      w_chk_err  = 1'b0;
      w_chk_code = CMDERR_NONE;
      if (!halted) begin
         w_chk_err  = 1'b1;
         w_chk_code = CMDERR_HALTRESUME;
      end else if (r_aarsize != c_aarsize_32) begin
         w_chk_err  = 1'b1;
         w_chk_code = CMDERR_NOTSUP;
`ifndef DM_ABSTRACT_POSTINCREMENT_EN
      end else if (r_postinc) begin
         w_chk_err  = 1'b1;
         w_chk_code = CMDERR_NOTSUP;
`endif
      end else if (r_transfer) begin
         if (w_in_csr) begin
            if (csr_invalid) begin
               w_chk_err  = 1'b1;
               w_chk_code = CMDERR_EXCEPT;
            end
         end else if (!w_in_gpr) begin
            w_chk_err  = 1'b1;
            w_chk_code = CMDERR_EXCEPT;
         end
      end
   end

   always_comb begin
      w_err_set  = 1'b0;
      w_err_code = CMDERR_NONE;
      if (r_state == ST_CHECK && w_chk_err) begin
         w_err_set  = 1'b1;
         w_err_code = w_chk_code;
      end else if (cmd_valid && r_state != ST_IDLE) begin
         w_err_set  = 1'b1;
         w_err_code = CMDERR_BUSY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmderr    <= CMDERR_NONE;
         r_regno     <= '0;
         r_write     <= 1'b0;
         r_transfer  <= 1'b0;
         r_postinc   <= 1'b0;
         r_aarsize   <= '0;
         r_busy      <= 1'b0;
         r_data0_out <= '0;
         r_data0_we  <= 1'b0;
         r_csr_addr  <= '0;
         r_csr_f3    <= c_csr_f3_read;
         r_csr_wdata <= '0;
         r_csr_write <= 1'b0;
         r_rf_addr   <= '0;
         r_rf_wdata  <= '0;
         r_rf_we     <= 1'b0;
`ifdef DM_ABSTRACT_POSTINCREMENT_EN
         r_regno_out <= '0;
         r_regno_we  <= 1'b0;
`endif
      end else begin
         r_data0_we  <= 1'b0;
         r_csr_write <= 1'b0;
         r_rf_we     <= 1'b0;
`ifdef DM_ABSTRACT_POSTINCREMENT_EN
         r_regno_we  <= 1'b0;
`endif
         // First error sticks; a new error beats a simultaneous W1C clear.
         if (w_err_set && r_cmderr == CMDERR_NONE)
            r_cmderr <= w_err_code;
         else
            r_cmderr <= cmderr_e'(r_cmderr & ~cmderr_clr);

         case (r_state)
            ST_IDLE: begin
               r_csr_f3 <= c_csr_f3_read;
               if (cmd_valid && r_cmderr == CMDERR_NONE) begin
                  r_state    <= ST_CHECK;
                  r_busy     <= 1'b1;
                  r_regno    <= cmd_regno;
                  r_write    <= cmd_write;
                  r_transfer <= cmd_transfer;
                  r_postinc  <= cmd_postinc;
                  r_aarsize  <= cmd_aarsize;
                  r_rf_addr  <= w_cmd_gpr_idx;
                  if (cmd_regno <= c_csr_regno_last) begin
                     r_csr_addr <= cmd_regno[11:0];
                     r_csr_f3   <= cmd_write ? c_csr_f3_write : c_csr_f3_read;
                  end
               end
            end
            ST_CHECK: begin
               if (w_chk_err) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (!r_transfer) begin
                  r_state <= w_done_state;
                  r_busy  <= (w_done_state != ST_IDLE);
`ifdef DM_ABSTRACT_POSTINCREMENT_EN
                  r_regno_out <= r_regno + 16'd1;
                  r_regno_we  <= r_postinc;
`endif
               end else if (r_write) begin
                  r_state <= ST_WRITE;
                  if (w_in_csr) begin
                     r_csr_wdata <= data0_in;
                     r_csr_write <= 1'b1;
                  end else begin
                     r_rf_wdata  <= data0_in;
                     r_rf_we     <= 1'b1;
                  end
               end else begin
                  r_state     <= ST_READ;
                  r_data0_out <= w_in_csr ? csr_rdata : rf_rdata;
                  r_data0_we  <= 1'b1;
               end
            end
            ST_READ, ST_WRITE: begin
               r_state <= w_done_state;
               r_busy  <= (w_done_state != ST_IDLE);
`ifdef DM_ABSTRACT_POSTINCREMENT_EN
               r_regno_out <= r_regno + 16'd1;
               r_regno_we  <= r_postinc;
`endif
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Strobes are masked by reset so an abort suppresses them in the reset cycle.
   assign data0_out = r_data0_out;
   assign data0_we  = r_data0_we & rst_n;
   assign busy      = r_busy;
   assign cmderr    = r_cmderr;
   assign csr_addr  = r_csr_addr;
   assign csr_f3    = r_csr_f3;
   assign csr_wdata = r_csr_wdata;
   assign csr_rs    = 5'd0;
   assign csr_write = r_csr_write & rst_n;
   assign rf_addr   = r_rf_addr;
   assign rf_wdata  = r_rf_wdata;
   assign rf_we     = r_rf_we & rst_n;
`ifdef DM_ABSTRACT_POSTINCREMENT_EN
   assign regno_out = r_regno_out;
   assign regno_we  = r_regno_we & rst_n;
`else
   assign regno_out = 16'h0000;
   assign regno_we  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_abstract_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_abstract_access
// Brief    : Scoreboard bench for dm_abstract_access with CSR file and GPR
//            models. Honours DM_ABSTRACT_POSTINCREMENT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_abstract_access;

   localparam int c_k_rd     = 0;
   localparam int c_k_csr_wr = 1;
   localparam int c_k_rf_wr  = 2;
   localparam int c_k_inc    = 3;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [2:0]  cmd_aarsize;
   logic        cmd_postinc;
   logic        cmd_transfer;
   logic        cmd_write;
   logic [15:0] cmd_regno;
   logic        halted;
   logic [2:0]  cmderr_clr;
   logic [31:0] data0_in;
   logic [31:0] data0_out;
   logic        data0_we;
   logic [15:0] regno_out;
   logic        regno_we;
   logic        busy;
   logic [2:0]  cmderr;
   logic [11:0] csr_addr;
   logic [2:0]  csr_f3;
   logic [31:0] csr_wdata;
   logic [4:0]  csr_rs;
   logic        csr_write;
   logic [31:0] csr_rdata;
   logic        csr_invalid;
   logic [4:0]  rf_addr;
   logic [31:0] rf_rdata;
   logic [31:0] rf_wdata;
   logic        rf_we;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat;

   always #5 clk = ~clk;

   dm_abstract_access dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_aarsize(cmd_aarsize),
      .cmd_postinc(cmd_postinc), .cmd_transfer(cmd_transfer), .cmd_write(cmd_write),
      .cmd_regno(cmd_regno), .halted(halted), .cmderr_clr(cmderr_clr),
      .data0_in(data0_in), .data0_out(data0_out), .data0_we(data0_we),
      .regno_out(regno_out), .regno_we(regno_we), .busy(busy), .cmderr(cmderr),
      .csr_addr(csr_addr), .csr_f3(csr_f3), .csr_wdata(csr_wdata), .csr_rs(csr_rs),
      .csr_write(csr_write), .csr_rdata(csr_rdata), .csr_invalid(csr_invalid),
      .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_wdata(rf_wdata), .rf_we(rf_we)
   );

   // Core-side models: a few CSRs (0xF11 read-only, 0x340 writable) and a GPR file.
   logic [31:0] mscratch = 32'h0;
   logic [31:0] rf [32];
   logic        rf_init = 1'b0;

   always_comb begin
      case (csr_addr)
         12'h341: csr_rdata = 32'h8000_0010;
         12'h340: csr_rdata = mscratch;
         12'hF11: csr_rdata = 32'h0000_0489;
         default: csr_rdata = 32'h0;
      endcase
   end
   assign csr_invalid = (csr_addr[11:10] == 2'b11 && csr_f3 == 3'b001) || (csr_addr == 12'h7FF);
   assign rf_rdata    = rf[rf_addr];

   always @(posedge clk) begin
      if (csr_write && csr_addr == 12'h340) mscratch <= csr_wdata;
      if (!rf_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
         rf_init <= 1'b1;
      end else if (rf_we && rf_addr != 5'd0) begin
         rf[rf_addr] <= rf_wdata;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_txn(input int kind, input logic [15:0] addr, input logic [31:0] data);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic take(input int kind, input logic [15:0] addr, input logic [31:0] data);
      exp_t e;
      if (sb.size() == 0) begin
         check_value("unexpected_strobe_kind", 32'(kind), 32'hFFFF_FFFF);
      end else begin
         e = sb.pop_front();
         check_value("sb_kind", 32'(kind), 32'(e.kind));
         if (kind == c_k_csr_wr || kind == c_k_rf_wr)
            check_value("sb_addr", 32'(addr), 32'(e.addr));
         check_value("sb_data", data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (data0_we) take(c_k_rd, 16'h0, data0_out);
      if (csr_write) begin
         take(c_k_csr_wr, {4'h0, csr_addr}, csr_wdata);
         check_value("csr_f3_on_write", 32'(csr_f3), 32'(3'b001));
      end
      if (rf_we)    take(c_k_rf_wr, {11'h0, rf_addr}, rf_wdata);
      if (regno_we) take(c_k_inc, 16'h0, {16'h0, regno_out});
   end

   // Called just after a rising edge; returns cycles from cmd_valid until busy drops.
   task automatic run_cmd(input logic wr, input logic [15:0] regno, input logic [2:0] size,
                          input logic tr, input logic pi, input logic [31:0] d0, output int l);
      cmd_valid    = 1'b1;
      cmd_write    = wr;
      cmd_regno    = regno;
      cmd_aarsize  = size;
      cmd_transfer = tr;
      cmd_postinc  = pi;
      data0_in     = d0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      l = 1;
      while (busy && l < 10) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic clear_err();
      cmderr_clr = 3'b111;
      @(posedge clk); #1;
      cmderr_clr = 3'b000;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_aarsize = 3'd2; cmd_postinc = 1'b0;
      cmd_transfer = 1'b0; cmd_write = 1'b0; cmd_regno = 16'h0; halted = 1'b1;
      cmderr_clr = 3'b000; data0_in = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      check_value("rst_busy", 32'(busy), 32'd0);
      check_value("rst_cmderr", 32'(cmderr), 32'd0);
      check_value("rst_csr_f3", 32'(csr_f3), 32'(3'b010));
      check_value("rst_csr_addr", 32'(csr_addr), 32'd0);
      check_value("rst_data0_out", data0_out, 32'd0);
      check_value("rst_strobes", 32'({data0_we, csr_write, rf_we, regno_we}), 32'd0);
      check_value("csr_rs_zero", 32'(csr_rs), 32'd0);

      expect_txn(c_k_rd, 16'h0, 32'h8000_0010);
      run_cmd(1'b0, 16'h0341, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      check_value("rd_mepc_lat", 32'(lat), 32'd3);
      check_value("rd_mepc_err", 32'(cmderr), 32'd0);

      expect_txn(c_k_rf_wr, 16'd5, 32'hDEAD_BEEF);
      run_cmd(1'b1, 16'h1005, 3'd2, 1'b1, 1'b0, 32'hDEAD_BEEF, lat);
      check_value("wr_x5_lat", 32'(lat), 32'd3);
      expect_txn(c_k_rd, 16'h0, 32'hDEAD_BEEF);
      run_cmd(1'b0, 16'h1005, 3'd2, 1'b1, 1'b0, 32'h0, lat);

      expect_txn(c_k_rf_wr, 16'd0, 32'h0000_1234);
      run_cmd(1'b1, 16'h1000, 3'd2, 1'b1, 1'b0, 32'h0000_1234, lat);
      expect_txn(c_k_rd, 16'h0, 32'h0);
      run_cmd(1'b0, 16'h1000, 3'd2, 1'b1, 1'b0, 32'h0, lat);

      expect_txn(c_k_rd, 16'h0, 32'h1000_001F);
      run_cmd(1'b0, 16'h101F, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      check_value("rd_x31_err", 32'(cmderr), 32'd0);

      expect_txn(c_k_csr_wr, 16'h340, 32'hA5A5_5A5A);
      run_cmd(1'b1, 16'h0340, 3'd2, 1'b1, 1'b0, 32'hA5A5_5A5A, lat);
      check_value("wr_csr_lat", 32'(lat), 32'd3);
      expect_txn(c_k_rd, 16'h0, 32'hA5A5_5A5A);
      run_cmd(1'b0, 16'h0340, 3'd2, 1'b1, 1'b0, 32'h0, lat);

      run_cmd(1'b1, 16'h0F11, 3'd2, 1'b1, 1'b0, 32'h1111_2222, lat);
      check_value("ro_csr_lat", 32'(lat), 32'd2);
      check_value("ro_csr_err", 32'(cmderr), 32'd3);
      run_cmd(1'b0, 16'h0341, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      check_value("ignored_lat", 32'(lat), 32'd1);
      check_value("ignored_err", 32'(cmderr), 32'd3);
      clear_err();
      check_value("clr_err", 32'(cmderr), 32'd0);

      halted = 1'b0;
      run_cmd(1'b0, 16'h0341, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      halted = 1'b1;
      check_value("not_halted_lat", 32'(lat), 32'd2);
      check_value("not_halted_err", 32'(cmderr), 32'd4);
      clear_err();

      run_cmd(1'b0, 16'h0341, 3'd3, 1'b1, 1'b0, 32'h0, lat);
      check_value("aarsize3_err", 32'(cmderr), 32'd2);
      clear_err();

      run_cmd(1'b0, 16'h2000, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      check_value("regno2000_err", 32'(cmderr), 32'd3);
      clear_err();
      run_cmd(1'b1, 16'h1020, 3'd2, 1'b1, 1'b0, 32'h0, lat);
      check_value("regno1020_err", 32'(cmderr), 32'd3);
      clear_err();

      run_cmd(1'b0, 16'h2000, 3'd2, 1'b0, 1'b0, 32'h0, lat);
      check_value("notransfer_lat", 32'(lat), 32'd2);
      check_value("notransfer_err", 32'(cmderr), 32'd0);

`ifdef DM_ABSTRACT_POSTINCREMENT_EN
      expect_txn(c_k_inc, 16'h0, 32'h0000_0000);
      run_cmd(1'b0, 16'hFFFF, 3'd2, 1'b0, 1'b1, 32'h0, lat);
      check_value("postinc_wrap_lat", 32'(lat), 32'd3);
      check_value("postinc_wrap_err", 32'(cmderr), 32'd0);
      expect_txn(c_k_rd, 16'h0, 32'h8000_0010);
      expect_txn(c_k_inc, 16'h0, 32'h0000_0342);
      run_cmd(1'b0, 16'h0341, 3'd2, 1'b1, 1'b1, 32'h0, lat);
      check_value("postinc_rd_lat", 32'(lat), 32'd4);
`else
      run_cmd(1'b0, 16'hFFFF, 3'd2, 1'b0, 1'b1, 32'h0, lat);
      check_value("postinc_off_lat", 32'(lat), 32'd2);
      check_value("postinc_off_err", 32'(cmderr), 32'd2);
      clear_err();
`endif

      // Second strobe while busy, colliding with a W1C clear of cmderr.
      expect_txn(c_k_rd, 16'h0, 32'h8000_0010);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 16'h0341; cmd_aarsize = 3'd2;
      cmd_transfer = 1'b1; cmd_postinc = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      cmd_valid = 1'b1; cmderr_clr = 3'b111;
      step();
      cmd_valid = 1'b0; cmderr_clr = 3'b000;
      check_value("busy_err_code", 32'(cmderr), 32'd1);
      check_value("busy_err_idle", 32'(busy), 32'd0);
      clear_err();

      // Hart leaves debug mode after the legality check.
      expect_txn(c_k_rd, 16'h0, 32'h8000_0010);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      halted = 1'b0;
      step();
      halted = 1'b1;
      check_value("halt_drop_err", 32'(cmderr), 32'd0);
      check_value("halt_drop_busy", 32'(busy), 32'd0);

      // Reset asserted while the GPR write strobe is pending.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_regno = 16'h1007; data0_in = 32'h5555_5555;
      step();
      cmd_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_value("rst_mid_busy", 32'(busy), 32'd0);
      check_value("rst_mid_err", 32'(cmderr), 32'd0);
      expect_txn(c_k_rd, 16'h0, 32'h1000_0007);
      run_cmd(1'b0, 16'h1007, 3'd2, 1'b1, 1'b0, 32'h0, lat);

      repeat (3) step();
      check_value("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
